// File: rtl/aes_pkg.sv
// Shared types and constants for the AES input sequencer slice.
package aes_pkg;

  localparam int word_w_lp     = 32;
  localparam int key_words_lp  = 8;
  localparam int text_words_lp = 4;

  typedef enum logic [1:0] {
    NO_KEY    = 2'd0,
    KEY_LOAD  = 2'd1,
    KEY_READY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/aes_result_fifo.sv
// Result FIFO: circular buffer with a registered head, valid/yumi handshake
// and a full flag. The head reads as zero whenever the FIFO is empty.
module aes_result_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                pop;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign pop    = yumi_i & v_o;
  assign v_o    = (cnt_q != '0);
  assign full_o = (cnt_q == cnt_w_lp'(els_p));
  assign data_o = v_o ? mem_q[rd_q] : '0;

  // Next pointers and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_d  = v_i ? next_ptr(wr_q) : wr_q;
    rd_d  = pop ? next_ptr(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (v_i && !pop)      cnt_d = cnt_q + cnt_w_lp'(1);
    else if (pop && !v_i) cnt_d = cnt_q - cnt_w_lp'(1);
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage: written on push, never reset (empty FIFO masks the head).
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/aes_input_sequencer.sv
// Collects 32-bit key/plaintext words, launches 128-bit blocks into a
// fixed-latency encryption core and buffers results in a credit-protected FIFO.
module aes_input_sequencer
  import aes_pkg::*;
#(
  parameter int core_latency_p = 16,
  parameter int fifo_els_p     = 4
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         in_v_i,
  input  logic         in_key_i,
  input  logic [31:0]  in_data_i,
  output logic         in_ready_o,
  output logic [255:0] initial_key_o,
  output logic [127:0] plaintext_o,
  output logic         launch_o,
  input  logic [127:0] ciphertext_i,
  output logic         out_v_o,
  output logic [127:0] out_data_o,
  input  logic         out_yumi_i
);

  localparam int cred_w_lp     = $clog2(fifo_els_p + 1);
  localparam int key_cnt_w_lp  = $clog2(key_words_lp);
  localparam int text_cnt_w_lp = $clog2(text_words_lp);

  seq_state_e               state_q, state_d;
  logic [key_cnt_w_lp-1:0]  key_cnt_q, key_cnt_d;
  logic [text_cnt_w_lp-1:0] text_cnt_q, text_cnt_d;
  logic [cred_w_lp-1:0]     credits_q, credits_d;
  logic [255:0]             key_q, key_d;
  logic [127:0]             asm_q, asm_d;
  logic [127:0]             plaintext_q, plaintext_d;
  logic                     launch_q, launch_d;
  logic                     alive_q;
  logic [core_latency_p-1:0] dly_q, dly_d;

  logic in_flight, key_ok, text_ok;
  logic acc, key_acc, text_acc, text_last;
  logic push, pop, fifo_full;

  // Readiness depends only on registered state, so out_yumi_i never reaches
  // in_ready_o combinationally; alive_q keeps it low through reset.
  assign in_flight  = launch_q | (|dly_q);
  assign key_ok     = (text_cnt_q == '0) && !in_flight;
  assign text_ok    = (state_q == KEY_READY) &&
                      ((text_cnt_q != text_cnt_w_lp'(text_words_lp - 1)) || (credits_q != '0));
  assign in_ready_o = alive_q & (in_key_i ? key_ok : text_ok);

  assign acc       = in_v_i & in_ready_o;
  assign key_acc   = acc & in_key_i;
  assign text_acc  = acc & ~in_key_i;
  assign text_last = text_acc && (text_cnt_q == text_cnt_w_lp'(text_words_lp - 1));
  assign pop       = out_v_o & out_yumi_i;
  assign push      = dly_q[core_latency_p-1];

  assign initial_key_o = key_q;
  assign plaintext_o   = plaintext_q;
  assign launch_o      = launch_q;

  // Word packing, key FSM, block launch and credit accounting.
  always_comb begin
    state_d     = state_q;
    key_cnt_d   = key_cnt_q;
    text_cnt_d  = text_cnt_q;
    key_d       = key_q;
    asm_d       = asm_q;
    plaintext_d = plaintext_q;
    launch_d    = 1'b0;
    credits_d   = credits_q;

    if (key_acc) begin
      for (int i = 0; i < key_words_lp; i++)
        if (key_cnt_q == key_cnt_w_lp'(i))
          key_d[(key_words_lp-1-i)*word_w_lp +: word_w_lp] = in_data_i;
      key_cnt_d = key_cnt_q + key_cnt_w_lp'(1);
      state_d   = (key_cnt_q == key_cnt_w_lp'(key_words_lp - 1)) ? KEY_READY : KEY_LOAD;
    end

    if (text_acc) begin
      for (int i = 0; i < text_words_lp; i++)
        if (text_cnt_q == text_cnt_w_lp'(i))
          asm_d[(text_words_lp-1-i)*word_w_lp +: word_w_lp] = in_data_i;
      if (text_last) begin
        plaintext_d = asm_d;
        text_cnt_d  = '0;
        launch_d    = 1'b1;
      end else begin
        text_cnt_d  = text_cnt_q + text_cnt_w_lp'(1);
      end
    end

    if (text_last && !pop)      credits_d = credits_q - cred_w_lp'(1);
    else if (pop && !text_last) credits_d = credits_q + cred_w_lp'(1);

    dly_d    = '0;
    dly_d[0] = launch_q;
    for (int i = 1; i < core_latency_p; i++) dly_d[i] = dly_q[i-1];
  end

  // Sequencer registers; key and plaintext outputs read zero in reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= NO_KEY;
      key_cnt_q   <= '0;
      text_cnt_q  <= '0;
      credits_q   <= cred_w_lp'(fifo_els_p);
      key_q       <= '0;
      plaintext_q <= '0;
      launch_q    <= 1'b0;
      alive_q     <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_cnt_q   <= key_cnt_d;
      text_cnt_q  <= text_cnt_d;
      credits_q   <= credits_d;
      key_q       <= key_d;
      plaintext_q <= plaintext_d;
      launch_q    <= launch_d;
      alive_q     <= 1'b1;
      dly_q       <= dly_d;
    end
  end

  // Plaintext assembly register: partial block, no reset needed.
  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
  end

  aes_result_fifo #(
    .els_p  (fifo_els_p),
    .width_p(128)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (push),
    .data_i   (ciphertext_i),
    .v_o      (out_v_o),
    .data_o   (out_data_o),
    .yumi_i   (out_yumi_i),
    .full_o   (fifo_full)
  );

  // Credits guarantee a push never lands on a full FIFO without a pop.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push && fifo_full && !pop));

  a_credit_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    credits_q <= cred_w_lp'(fifo_els_p));

endmodule

// File: tb/tb_aes_input_sequencer.sv
// Directed bench for aes_input_sequencer with a fixed-latency core model.
module tb_aes_input_sequencer;

  localparam int LAT = 16;
  localparam int ELS = 4;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk_i;
  logic         reset_n_i;
  logic         in_v_i;
  logic         in_key_i;
  logic [31:0]  in_data_i;
  logic         in_ready_o;
  logic [255:0] initial_key_o;
  logic [127:0] plaintext_o;
  logic         launch_o;
  logic [127:0] ciphertext_i;
  logic         out_v_o;
  logic [127:0] out_data_o;
  logic         out_yumi_i;

  aes_input_sequencer #(
    .core_latency_p(LAT),
    .fifo_els_p    (ELS)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .in_v_i       (in_v_i),
    .in_key_i     (in_key_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .initial_key_o(initial_key_o),
    .plaintext_o  (plaintext_o),
    .launch_o     (launch_o),
    .ciphertext_i (ciphertext_i),
    .out_v_o      (out_v_o),
    .out_data_o   (out_data_o),
    .out_yumi_i   (out_yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Core model: the FIPS-197 AES-256 vector, otherwise a simple keyed mix.
  function automatic logic [127:0] core_f(input logic [255:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ k[255:128] ^ k[127:0];
  endfunction

  logic [127:0] pipe [LAT];
  always @(posedge clk_i) begin
    pipe[0] <= core_f(initial_key_o, plaintext_o);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ciphertext_i = pipe[LAT-1];

  int cyc = 0;
  int launch_cnt = 0;
  int launch_cyc = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (launch_o) begin
      launch_cnt <= launch_cnt + 1;
      launch_cyc <= cyc;
    end
  end

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one word from a negedge; returns at a negedge.
  task automatic put(input logic k, input logic [31:0] d, input int max_wait, output logic ok);
    ok = 1'b0;
    in_v_i = 1'b1; in_key_i = k; in_data_i = d;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (in_ready_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    if (ok) @(negedge clk_i);
    in_v_i = 1'b0;
  endtask

  task automatic pop_chk(input string name);
    logic [127:0] e;
    for (int i = 0; i < 60 && !out_v_o; i++) @(negedge clk_i);
    chk({name, "_v"}, out_v_o, 1);
    if (out_v_o) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      chk({name, "_data"}, out_data_o, e);
      out_yumi_i = 1'b1;
      @(negedge clk_i);
      out_yumi_i = 1'b0;
    end
  endtask

  task automatic load_key(input logic [255:0] k, input string name);
    logic ok;
    for (int i = 0; i < 8; i++) begin
      put(1'b1, k[(7-i)*32 +: 32], 1, ok);
      chk($sformatf("%s_w%0d", name, i), ok, 1);
    end
  endtask

  function automatic logic [31:0] tword(input int b, input int w);
    return 32'((w + 1) << 28) | 32'(b);
  endfunction

  function automatic logic [127:0] tblock(input int b);
    return {tword(b, 0), tword(b, 1), tword(b, 2), tword(b, 3)};
  endfunction

  task automatic send_block(input int b, input string name);
    logic ok;
    for (int w = 0; w < 4; w++) begin
      put(1'b0, tword(b, w), 1, ok);
      chk($sformatf("%s_b%0d_w%0d", name, b, w), ok, 1);
    end
    exp_q.push_back(core_f(FIPS_KEY, tblock(b)));
  endtask

  typedef struct {
    logic        key;
    logic [31:0] data;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic [255:0] kbuf;
    logic [127:0] pbuf;
    int base;
    int vcount;

    reset_n_i = 1'b0; in_v_i = 1'b0; in_key_i = 1'b0; in_data_i = '0; out_yumi_i = 1'b0;

    kbuf = FIPS_KEY;
    pbuf = FIPS_PT;
    vecs[0] = '{1'b0, 32'hdeadbeef, 1'b0};
    vecs[1] = '{1'b0, 32'h0badf00d, 1'b0};
    for (int i = 0; i < 8; i++) vecs[2+i]  = '{1'b1, kbuf[(7-i)*32 +: 32], 1'b1};
    for (int i = 0; i < 4; i++) vecs[10+i] = '{1'b0, pbuf[(3-i)*32 +: 32], 1'b1};

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_ready", in_ready_o, 0);
    chk("rst_launch", launch_o, 0);
    chk("rst_out_v", out_v_o, 0);
    chk("rst_key", initial_key_o, 0);
    chk("rst_pt", plaintext_o, 0);
    chk("rst_out_data", out_data_o, 0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Table: text in NO_KEY rejected, then FIPS key and plaintext accepted
    for (int i = 0; i < 14; i++) begin
      put(vecs[i].key, vecs[i].data, 1, ok);
      chk($sformatf("vec%0d_rdy", i), ok, vecs[i].exp_rdy);
      if (i == 1) chk("nokey_launch_cnt", launch_cnt, 0);
    end
    chk("fips_launch", launch_o, 1);
    chk("fips_key", initial_key_o, FIPS_KEY);
    chk("fips_pt", plaintext_o, FIPS_PT);
    @(negedge clk_i);
    chk("fips_launch_one_cycle", launch_o, 0);
    for (int i = 0; i < 60 && !out_v_o; i++) @(negedge clk_i);
    chk("fips_out_v", out_v_o, 1);
    chk("fips_latency", cyc - launch_cyc, LAT + 1);
    chk("fips_ct", out_data_o, FIPS_CT);
    chk("fips_launch_cnt", launch_cnt, 1);
    out_yumi_i = 1'b1;
    @(negedge clk_i);
    out_yumi_i = 1'b0;
    chk("fips_drained", out_v_o, 0);

    // Credit exhaustion: four blocks launch, the 4th word of block 4 stalls
    base = launch_cnt;
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        put(1'b0, tword(b, w), 1, ok);
        chk($sformatf("fill_b%0d_w%0d", b, w), ok, (b == 4 && w == 3) ? 1'b0 : 1'b1);
      end
      if (b < 4) exp_q.push_back(core_f(FIPS_KEY, tblock(b)));
    end
    chk("fill_credits0", dut.credits_q, 0);
    repeat (LAT + 6) @(negedge clk_i);
    chk("fill_launches", launch_cnt - base, 4);
    put(1'b0, tword(4, 3), 1, ok);
    chk("full_stall", ok, 0);
    chk("full_out_v", out_v_o, 1);
    pop_chk("full_b0");
    put(1'b0, tword(4, 3), 2, ok);
    chk("credit_return_accept", ok, 1);
    exp_q.push_back(core_f(FIPS_KEY, tblock(4)));
    pop_chk("full_b1");
    pop_chk("full_b2");
    pop_chk("full_b3");
    pop_chk("full_b4");
    chk("full_launches", launch_cnt - base, 5);
    chk("full_credits", dut.credits_q, ELS);

    // Key word blocked while two blocks are in flight
    send_block(5, "inflt");
    send_block(6, "inflt");
    in_v_i = 1'b1; in_key_i = 1'b1; in_data_i = 32'hcafef00d;
    #1;
    chk("key_blocked", in_ready_o, 0);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      #1;
      if (in_ready_o) begin ok = 1'b1; break; end
    end
    chk("key_ready_seen", ok, 1);
    chk("key_ready_delay", cyc - launch_cyc, LAT + 1);
    @(negedge clk_i);
    in_v_i = 1'b0;
    chk("key_state_load", dut.state_q, aes_pkg::KEY_LOAD);
    chk("key_word0", initial_key_o[255:224], 32'hcafef00d);
    put(1'b0, 32'h12345678, 1, ok);
    chk("key_load_text_rej", ok, 0);
    pop_chk("inflt_b5");

    // Reset mid key load with one result still buffered
    reset_n_i = 1'b0;
    #1;
    chk("rst1_state", dut.state_q, aes_pkg::NO_KEY);
    chk("rst1_ready", in_ready_o, 0);
    chk("rst1_out_v", out_v_o, 0);
    chk("rst1_key", initial_key_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    chk("rst1_credits", dut.credits_q, ELS);

    // Reset with three blocks in flight
    load_key(FIPS_KEY, "rkey");
    base = launch_cnt;
    for (int b = 7; b < 10; b++) send_block(b, "rblk");
    @(negedge clk_i);
    chk("rst2_launches", launch_cnt - base, 3);
    reset_n_i = 1'b0;
    #1;
    chk("rst2_launch", launch_o, 0);
    chk("rst2_ready", in_ready_o, 0);
    chk("rst2_pt", plaintext_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    exp_q.delete();
    vcount = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk_i);
      if (out_v_o) vcount++;
    end
    chk("rst2_no_out_v", vcount, 0);
    chk("rst2_state", dut.state_q, aes_pkg::NO_KEY);
    chk("rst2_credits", dut.credits_q, ELS);
    put(1'b0, 32'h55aa55aa, 1, ok);
    chk("rst2_text_rej", ok, 0);
    chk("rst2_no_launch", launch_cnt - base, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
